// File: rtl/somasub_pkg.sv
// Shared types and helpers for the bit-serial add/subtract unit.
package somasub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Single full-adder cell, reused once per cycle by the serial datapath.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority carry.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/somasub_serial.sv
// Bit-serial add/subtract unit: one operand pair per transaction, WIDTH
// cycles through a single full adder, result plus zero/sinal/overflow/carry
// flags presented on a valid/ready output.
// Optional macro SOMASUB_STICKY_OVF_EN adds ovf_clr / ovf_sticky.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// CALC  | one result bit per edge, LSB first
// DONE  | result valid, holding until out_ready
module somasub_serial
  import somasub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             sinal,
  output logic             overflow,
`ifdef SOMASUB_STICKY_OVF_EN
  input  logic             ovf_clr,
  output logic             ovf_sticky,
`endif
  output logic             carry
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_IN_BIT = CW'(WIDTH - 2);

  state_t           state, next_state;
  logic             rdy_q;
  logic [WIDTH-1:0] sa, sb;
  logic             cy, c_msb_in;
  logic [CW-1:0]    cnt;
  logic             s, cout;
  logic             accept, finish;
  logic [WIDTH-1:0] res_full;

  // SA doubles as the result register: sum bits enter at the MSB as
  // operand bits leave at the LSB, so after WIDTH shifts it holds the sum.
  full_adder_bit u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (cy),
    .s    (s),
    .cout (cout)
  );

  assign res_full = {s, sa[WIDTH-1:1]};
  assign in_ready = rdy_q;

  // Next-state decode and handshake qualifiers.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (in_valid && rdy_q) begin
        accept     = 1'b1;
        next_state = CALC;
      end
      CALC: if (cnt == LAST_BIT) begin
        finish     = 1'b1;
        next_state = DONE;
      end
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; in_ready is registered so it stays low through reset
  // and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= next_state;
      rdy_q <= (next_state == IDLE);
    end
  end

  // Serial datapath and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa        <= '0;
      sb        <= '0;
      cy        <= 1'b0;
      c_msb_in  <= 1'b0;
      cnt       <= '0;
      r         <= '0;
      zero      <= 1'b0;
      sinal     <= 1'b0;
      overflow  <= 1'b0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        sa  <= a;
        sb  <= b ^ {WIDTH{op == OP_SUB}};
        cy  <= op;
        cnt <= '0;
      end else if (state == CALC) begin
        sa  <= res_full;
        sb  <= {1'b0, sb[WIDTH-1:1]};
        cy  <= cout;
        cnt <= cnt + 1'b1;
        if (cnt == MSB_IN_BIT) c_msb_in <= cout;
      end
      if (finish) begin
        r         <= res_full;
        carry     <= cout;
        overflow  <= c_msb_in ^ cout;
        zero      <= ~|res_full;
        sinal     <= s;
        out_valid <= 1'b1;
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SOMASUB_STICKY_OVF_EN
  // Sticky overflow: clear has priority over a coincident new overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             ovf_sticky <= 1'b0;
    else if (ovf_clr)                       ovf_sticky <= 1'b0;
    else if (finish && (c_msb_in ^ cout))   ovf_sticky <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_somasub_serial.sv
module tb_somasub_serial;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic         zero, sinal, overflow, carry;
`ifdef SOMASUB_STICKY_OVF_EN
  logic         ovf_clr;
  logic         ovf_sticky;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  somasub_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .zero      (zero),
    .sinal     (sinal),
    .overflow  (overflow),
`ifdef SOMASUB_STICKY_OVF_EN
    .ovf_clr   (ovf_clr),
    .ovf_sticky(ovf_sticky),
`endif
    .carry     (carry)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] r;
    logic         z;
    logic         s;
    logic         v;
    logic         c;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one operand pair and wait for out_valid; returns edges from accept.
  task automatic start_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic top, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_accept", int'(in_ready), 1);
    a = ta; b = tb_; op = top; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    check("in_ready_low_in_calc", int'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, "_r"},    int'(r),        int'(v.r));
    check({tag, "_zero"}, int'(zero),     int'(v.z));
    check({tag, "_sin"},  int'(sinal),    int'(v.s));
    check({tag, "_ovf"},  int'(overflow), int'(v.v));
    check({tag, "_cy"},   int'(carry),    int'(v.c));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_drop", int'(out_valid), 0);
    check("in_ready_after_drain", int'(in_ready), 1);
  endtask

  initial begin
    int   lat;
    vec_t bp;

    //          a        b        op    r        z     s     v     c
    vecs[0] = '{4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{4'b0101, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'b0010, 4'b0011, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{4'b0111, 4'b1000, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b0;
`ifdef SOMASUB_STICKY_OVF_EN
    ovf_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_outputs", int'({r, zero, sinal, overflow, carry}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_release", int'(in_ready), 1);

    for (int i = 0; i < 9; i++) begin
      start_txn(vecs[i].a, vecs[i].b, vecs[i].op, lat);
      check($sformatf("v%0d_latency", i), lat, W);
      check_result($sformatf("v%0d", i), vecs[i]);
`ifdef SOMASUB_STICKY_OVF_EN
      if (i == 1) begin
        check("sticky_set", int'(ovf_sticky), 1);
      end
`endif
      drain();
`ifdef SOMASUB_STICKY_OVF_EN
      if (i == 1) begin
        check("sticky_hold", int'(ovf_sticky), 1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("sticky_clear", int'(ovf_sticky), 0);
      end
`endif
    end

    // Backpressure: 6+1 held for 5 cycles.
    bp = '{4'b0110, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0};
    start_txn(bp.a, bp.b, bp.op, lat);
    check("bp_latency", lat, W);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_valid", k), int'(out_valid), 1);
      check($sformatf("bp_hold%0d_in_ready", k), int'(in_ready), 0);
      check_result($sformatf("bp_hold%0d", k), bp);
    end
    drain();

    // Reset two edges into CALC aborts; outputs clear asynchronously.
    @(negedge clk);
    a = 4'b0011; b = 4'b0100; op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", int'({r, zero, sinal, overflow, carry}), 0);
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_in_ready", int'(in_ready), 0);
    repeat (6) @(posedge clk);
    #1;
    check("rst_no_result", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_txn(4'b0001, 4'b0001, 1'b0, lat);
    check("post_rst_latency", lat, W);
    check_result("post_rst", '{4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0});
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/somasub_serial.md
Name: somasub_serial

Overview:
- Bit-serial, multi-cycle add/subtract unit that consumes one operand pair per transaction and returns the result with the zero, sinal, overflow and carry flags.
- It is the sequential, handshaked counterpart of the combinational add/sub block. It is used where area matters more than latency, with one full-adder cell reused for WIDTH cycles.
- It sits between an operand source (valid/ready) and a result sink (valid/ready).

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  unit can accept operands
- a  input  WIDTH  operand A (two's complement)
- b  input  WIDTH  operand B (two's complement)
- op  input  1  0 = A+B, 1 = A-B
- out_valid  output  1  result and flags valid
- out_ready  input  1  sink accepts result
- r  output  WIDTH  result
- zero  output  1  r == 0
- sinal  output  1  r[WIDTH-1]
- overflow  output  1  signed overflow
- carry  output  1  carry out of MSB (for subtraction, 1 = no borrow)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n=0: state=IDLE; r, zero, sinal, overflow, carry, out_valid all 0; in_ready=0. Releasing rst_n returns to IDLE, so in_ready=1 on the next cycle.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T: latch a into shift reg SA, latch b^{WIDTH{op}} into SB, cy=op, bit counter=0, go to CALC.
- CALC:
  - in_ready=0.
  - Each edge: s = SA[0]^SB[0]^cy; shift s into result reg from the MSB side; shift SA and SB right; cy = majority(SA[0], SB[0], cy); counter++.
  - On the edge that processes bit WIDTH-2, capture cy as c_msb_in (carry into MSB).
  - After WIDTH edges (edge T+WIDTH): r=full result, carry=cy, overflow=c_msb_in^cy, zero=~|r, sinal=r[WIDTH-1], out_valid=1, go to DONE.
- Latency: out_valid is high in the cycle after edge T+WIDTH.
- DONE:
  - Outputs held stable while out_valid=1 && out_ready=0.
  - On out_ready=1: out_valid falls at the next edge, go to IDLE. r and flags keep their last values.
- No overlap: a new transaction is accepted only in IDLE. in_valid during CALC or DONE is ignored and must be held by the source.
- Arithmetic: modulo 2^WIDTH. Subtraction is A + ~B + 1.
- Overflow rule: set iff A and B' (post-inversion) have equal sign and r sign differs.
- Reset mid-CALC or mid-DONE aborts the transaction with no partial result visible.
- in_valid with X on a/b outside the accept cycle has no effect.

Optional Feature:
- Macro: SOMASUB_STICKY_OVF_EN.
- When defined:
  - Adds input ovf_clr (1 bit) and output ovf_sticky (1 bit).
  - ovf_sticky is set at the edge where DONE is entered with overflow=1 and stays set until ovf_clr=1 or reset.
  - ovf_clr wins if it is coincident with a new overflow.
  - Reset value is 0.
- When undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Package somasub_pkg holds:
  - state enum {IDLE, CALC, DONE}
  - OP_ADD=1'b0, OP_SUB=1'b1
  - counter width function clog2(WIDTH)
- One natural sub-module: full_adder_bit (a, b, cin -> s, cout), instantiated once in the datapath.

Test Plan (WIDTH=4):
- 3+4 (op=0) -> r=0111, zero=0, sinal=0, overflow=0, carry=0; out_valid rises exactly 4 edges after accept.
- 7+1 (op=0) -> r=1000, sinal=1, overflow=1, carry=0; with the macro defined, ovf_sticky=1 until ovf_clr pulse.
- 5-5 (op=1) -> r=0000, zero=1, carry=1, overflow=0.
- 2-3 (op=1) -> r=1111, sinal=1, carry=0, overflow=0. Then -8-1 (1000-0001) -> r=0111, overflow=1, carry=1.
- Backpressure: hold out_ready=0 for 5 cycles after 6+1 -> r=0111 and all flags stable, in_ready=0 throughout; one cycle of out_ready=1 -> IDLE, in_ready=1.
- Reset: assert rst_n=0 two edges into CALC -> all outputs 0 immediately (async). After release, 1+1 completes with r=0010.
